ram_stream_reader: RTL and testbench



---
 rtl/ram_stream_pkg.sv | 19 +
 rtl/stream_skid_fifo.sv | 79 +++++++
 rtl/ram_stream_reader.sv | 163 ++++++++++++++++
 tb/tb_ram_stream_reader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_pkg.sv
// ----------------------------------------------------------------------------
// ram_stream_pkg
// Shared types and constants for the RAM stream reader:
//   state_e   : reader FSM states (IDLE, RUN, DRAIN)
//   BUF_DEPTH : number of entries in the output buffer
//   BUF_CNT_W : width of a counter able to hold 0..BUF_DEPTH
// ----------------------------------------------------------------------------
package ram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int BUF_DEPTH = 2;
  localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/stream_skid_fifo.sv
// ----------------------------------------------------------------------------
// stream_skid_fifo
// Small register FIFO that absorbs the RAM read latency against downstream
// backpressure. Push and pop in the same cycle are legal at any occupancy;
// the producer is responsible for never pushing into a full buffer without a
// simultaneous pop.
//
// Ports:
//   clock        in   system clock
//   reset        in   synchronous active-high reset
//   push_i       in   write push_data_i at the tail this cycle
//   push_data_i  in   data to write
//   pop_i        in   drop the head entry this cycle (ignored when empty)
//   head_o       out  oldest entry (meaningful while count_o != 0)
//   count_o      out  current occupancy, 0..BUF_DEPTH
// ----------------------------------------------------------------------------
module stream_skid_fifo
  import ram_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     push_data_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     head_o,
  output logic [BUF_CNT_W-1:0] count_o
);

  // BUF_DEPTH is a power of two, so pointers wrap by plain overflow.
  localparam int PTR_W = $clog2(BUF_DEPTH);

  logic [WIDTH-1:0]     mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [BUF_CNT_W-1:0] count_q, count_d;
  logic                 do_pop;

  always_comb begin
    // NOTE: every signal written here gets a default first; a branch that
    // skipped an assignment would otherwise infer a latch.
    do_pop   = pop_i && (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push_i, do_pop})
      2'b10:   count_d = count_q + BUF_CNT_W'(1);
      2'b01:   count_d = count_q - BUF_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the storage is only two words of flops, so it is reset too;
      // that keeps head_o (and the stream data) at 0 coming out of reset.
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// ----------------------------------------------------------------------------
// ram_stream_reader
// Walks a contiguous block-RAM address range (wrapping at DEPTH) on a start
// command and delivers each word on a valid/ready stream. The RAM has a
// one-cycle registered read; a two-entry buffer plus a credit check on
// issued reads absorbs backpressure without dropping or duplicating words.
//
// Ports:
//   clock      in   system clock (shared with the RAM read port)
//   reset      in   synchronous active-high reset; aborts any transfer
//   start      in   command strobe, accepted only while busy=0
//   base_addr  in   first address to read
//   length     in   number of words to deliver (0 allowed)
//   busy       out  high from start acceptance until the done cycle
//   done       out  one-cycle pulse after the last word handshakes
//   raddr      out  registered RAM read address
//   read_data  in   RAM data for the address sampled on the previous edge
//   out_data   out  stream data (buffer head)
//   out_valid  out  stream valid (buffer non-empty)
//   out_ready  in   stream ready; a beat moves on out_valid & out_ready
// ----------------------------------------------------------------------------
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter  int SIZE   = 8,
  parameter  int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] raddr,
  input  logic [SIZE-1:0]   read_data,
  output logic [SIZE-1:0]   out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int OCC_W = BUF_CNT_W + 1;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0]     rem_issue_q, rem_issue_d;
  logic [LEN_W-1:0]     rem_out_q, rem_out_d;
  logic                 inflight_q, inflight_d;

  logic                 accept;
  logic                 issue;
  logic                 pop;
  logic                 finish;
  logic [BUF_CNT_W-1:0] buf_count;
  logic [OCC_W-1:0]     occ_after_pop;

  // --------------------------------------------------------------------------
  // Output buffer: RAM data lands here one cycle after its read is issued.
  // --------------------------------------------------------------------------
  stream_skid_fifo #(
    .WIDTH (SIZE)
  ) u_buf (
    .clock       (clock),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i (read_data),
    .pop_i       (pop),
    .head_o      (out_data),
    .count_o     (buf_count)
  );

  assign out_valid = (buf_count != '0);
  assign pop       = out_valid && out_ready;
  assign raddr     = addr_q;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = (length == '0) ? DRAIN : RUN;
      end
      RUN: begin
        // Leave once the final read has been issued.
        if (issue && (rem_issue_q == LEN_W'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        // The done cycle may accept a fresh command back-to-back.
        if (finish) begin
          if (accept) state_d = (length == '0) ? DRAIN : RUN;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs and read-issue decision
  // --------------------------------------------------------------------------
  always_comb begin
    finish = (state_q == DRAIN) && (rem_out_q == '0);
    done   = finish;
    busy   = (state_q != IDLE) && !finish;
    accept = start && !busy;

    // Words already committed to the buffer (stored or still coming back
    // from the RAM), less the one leaving this cycle. A new read is only
    // issued if its data is guaranteed a slot when it arrives.
    occ_after_pop = OCC_W'(buf_count) + OCC_W'(inflight_q) - OCC_W'(pop);
    issue = (state_q == RUN) && (rem_issue_q != '0) &&
            (occ_after_pop < OCC_W'(BUF_DEPTH));
  end

  // --------------------------------------------------------------------------
  // Address / count datapath
  // --------------------------------------------------------------------------
  always_comb begin
    addr_d      = addr_q;
    rem_issue_d = rem_issue_q;
    rem_out_d   = rem_out_q;
    inflight_d  = issue;

    if (accept) begin
      addr_d      = base_addr;
      rem_issue_d = length;
      rem_out_d   = length;
    end else begin
      if (issue) begin
        addr_d      = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
        rem_issue_d = rem_issue_q - LEN_W'(1);
      end
      if (pop) rem_out_d = rem_out_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q      <= '0;
      rem_issue_q <= '0;
      rem_out_q   <= '0;
      inflight_q  <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      rem_issue_q <= rem_issue_d;
      rem_out_q   <= rem_out_d;
      inflight_q  <= inflight_d;
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// ----------------------------------------------------------------------------
// tb_ram_stream_reader
// Table-driven transfers, hand-written reset/back-to-back sequences and a
// randomized phase for ram_stream_reader (DEPTH=16 so wrap is exercised).
// The expected stream is derived from the bench's own RAM image: beat k of a
// transfer is ram[(base + k) mod DEPTH]; done must follow the last beat by
// one cycle; no more than two words may be read ahead of the consumer.
// ----------------------------------------------------------------------------
module tb_ram_stream_reader;

  localparam int SIZE  = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LW    = 5;

  typedef struct {
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    logic [31:0]   pat;        // out_ready in cycle c is pat[c % 32]
    int            spur;       // cycle of an extra start while busy (0 = none)
    int            exp_first;  // expected first out_valid cycle (-1 = never)
    int            exp_done;   // expected done cycle (-1 = not fixed)
  } xfer_t;

  logic            clock = 1'b0;
  logic            reset;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [LW-1:0]   length;
  logic            busy;
  logic            done;
  logic [AW-1:0]   raddr;
  logic [SIZE-1:0] read_data;
  logic [SIZE-1:0] out_data;
  logic            out_valid;
  logic            out_ready;

  logic [SIZE-1:0] ram [DEPTH];
  xfer_t           tbl [9];
  int              n_vec = 0;
  int              n_bad = 0;

  always #5 clock = ~clock;

  // Block RAM read port model: one-cycle registered read.
  always @(posedge clock) read_data <= ram[raddr];

  ram_stream_reader #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .raddr     (raddr),
    .read_data (read_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Runs one transfer. Cycle 0 is the cycle in which start is high; with
  // pre=1 that start was already driven by the previous call's done cycle.
  // With chain=1 the next command (nb, nl) is issued in this done cycle.
  task automatic do_xfer(input xfer_t v, input bit pre, input bit chain,
                         input logic [AW-1:0] nb, input logic [LW-1:0] nl);
    int              first   = -1;
    int              done_at = -1;
    int              last    = -1;
    int              beats   = 0;
    int              ah;
    bit              busy_err  = 1'b0;
    bit              stall_err = 1'b0;
    bit              ahead_err = 1'b0;
    bit              stalled   = 1'b0;
    logic [SIZE-1:0] held      = '0;

    if (!pre) begin
      @(negedge clock);
      start     = 1'b1;
      base_addr = v.base;
      length    = v.len;
      out_ready = v.pat[0];
    end

    for (int c = 1; c <= 1200 && done_at < 0; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (stalled && (!out_valid || out_data !== held)) stall_err = 1'b1;
      out_ready = v.pat[c % 32];
      if (done) begin
        done_at = c;
        if (busy || out_valid) busy_err = 1'b1;
        if (chain) begin
          start     = 1'b1;
          base_addr = nb;
          length    = nl;
        end
      end else begin
        if (!busy) busy_err = 1'b1;
        ah = (int'(raddr) - int'(v.base) - beats) & (DEPTH - 1);
        if (ah > 2) ahead_err = 1'b1;
        if (c == v.spur) begin
          start     = 1'b1;
          base_addr = v.base + AW'(5);
          length    = LW'(3);
        end
        if (out_valid) begin
          if (first < 0) first = c;
          if (out_ready) begin
            check("beat_data", 32'(out_data), 32'(ram[(int'(v.base) + beats) % DEPTH]));
            beats++;
            last = c;
          end
        end
        stalled = out_valid && !out_ready;
        held    = out_data;
      end
    end

    check("done_seen",      32'(done_at >= 0), 32'd1);
    check("beat_count",     32'(beats), 32'(v.len));
    check("first_valid",    32'(first), 32'(v.exp_first));
    check("done_after_last", 32'(done_at), (v.len == '0) ? 32'd1 : 32'(last + 1));
    if (v.exp_done >= 0) check("done_cycle", 32'(done_at), 32'(v.exp_done));
    check("busy_window",    32'(busy_err), 32'd0);
    check("stall_hold",     32'(stall_err), 32'd0);
    check("read_ahead",     32'(ahead_err), 32'd0);
    if (!chain) begin
      @(negedge clock);
      check("done_one_cycle", {29'd0, busy, done, out_valid}, 32'd0);
    end
  endtask

  function automatic xfer_t rand_xfer();
    xfer_t r;
    r.base      = AW'($urandom_range(0, DEPTH - 1));
    r.len       = LW'($urandom_range(0, 31));
    r.pat       = $urandom | $urandom | 32'h1;
    r.spur      = ($urandom_range(0, 1) == 1) ? 2 : 0;
    r.exp_first = (r.len == '0) ? -1 : 3;
    r.exp_done  = -1;
    return r;
  endfunction

  initial begin : main
    int    rb;
    bit    idle_err;
    bit    pre;
    bit    ch;
    xfer_t cur;
    xfer_t nxt;

    //            base   len    ready pattern  spur first done
    tbl[0] = '{4'd4,  5'd5,  32'hFFFF_FFFF, 0,  3,   8};   // basic, full rate
    tbl[1] = '{4'd14, 5'd4,  32'hFFFF_FFFF, 0,  3,   7};   // address wrap
    tbl[2] = '{4'd2,  5'd6,  32'hFFFF_FF4F, 0,  3,  -1};   // 1,0,0,1,0,1,1,1 from cycle 3
    tbl[3] = '{4'd7,  5'd0,  32'hFFFF_FFFF, 0, -1,   1};   // zero length
    tbl[4] = '{4'd9,  5'd5,  32'hFFFF_FFFF, 2,  3,   8};   // start while busy ignored
    tbl[5] = '{4'd0,  5'd20, 32'h5555_5555, 0,  3,  -1};   // longer than DEPTH, stalls
    tbl[6] = '{4'd3,  5'd31, 32'hFFFF_FFFF, 0,  3,  34};   // maximum length
    tbl[7] = '{4'd10, 5'd3,  32'hFFFF_FFFF, 0,  3,   6};   // chained into tbl[8]
    tbl[8] = '{4'd15, 5'd2,  32'hFFFF_FFFF, 0,  3,   5};

    for (int i = 0; i < DEPTH; i++) ram[i] = SIZE'(i);

    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_done",      32'(done), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_raddr",     32'(raddr), 32'd0);
    check("rst_out_data",  32'(out_data), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) do_xfer(tbl[i], 1'b0, 1'b0, '0, '0);
    do_xfer(tbl[7], 1'b0, 1'b1, tbl[8].base, tbl[8].len);
    do_xfer(tbl[8], 1'b1, 1'b0, '0, '0);

    // Reset in the middle of an 8-word transfer, after two beats.
    @(negedge clock);
    start     = 1'b1;
    base_addr = AW'(8);
    length    = LW'(8);
    out_ready = 1'b1;
    rb = 0;
    for (int c = 1; c < 40 && rb < 2; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (out_valid) rb++;
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy",      32'(busy), 32'd0);
    check("abort_done",      32'(done), 32'd0);
    check("abort_raddr",     32'(raddr), 32'd0);
    reset    = 1'b0;
    idle_err = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (done || busy || out_valid) idle_err = 1'b1;
    end
    check("abort_quiet", 32'(idle_err), 32'd0);
    do_xfer('{4'd0, 5'd3, 32'hFFFF_FFFF, 0, 3, 6}, 1'b0, 1'b0, '0, '0);

    // Randomized transfers over random RAM contents, sometimes back-to-back.
    for (int i = 0; i < DEPTH; i++) ram[i] = SIZE'($urandom);
    pre = 1'b0;
    cur = rand_xfer();
    for (int i = 0; i < 12; i++) begin
      nxt = rand_xfer();
      ch  = (i < 11) && ($urandom_range(0, 1) == 1);
      do_xfer(cur, pre, ch, nxt.base, nxt.len);
      pre = ch;
      cur = nxt;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
